sysbus_mem_responder: RTL

- Memory-side responder on the Sysbus; the far end of the CPU core's fetch/load initiator.
- Accepts one request at a time: a 64-bit byte address plus a 13-bit tag.
- Read: returns one 64-byte line as 8 × 64-bit beats on the response channel.
- Write: absorbs 8 data beats into an internal word array.
- Serves as the simulation memory behind the core, with a configurable read latency.

---
 rtl/sysbus_mem_responder_if.sv | 24 ++
 rtl/sysbus_mem_responder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sysbus_mem_responder_if.sv
// Sysbus request/response channel bundle between the initiator (master) and a memory responder (slave).
interface sysbus_mem_responder_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: one request at a time, 8-beat line reads and writes into a word array.
// Latency: first read beat LATENCY+1 cycles after the request edge; writes absorb 8 data beats.
// Backpressure: read beats held until bus_respack; write stalls on bus_reqcyc=0. SYSBUS_WRAP_BURST_EN = critical-word-first.
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int LATENCY        = 4
) (
  input logic                   clk,
  input logic                   reset,
  sysbus_mem_responder_if.slave bus
);
  localparam int         IDX_W    = $clog2(MEM_WORDS);
  localparam logic [7:0] LAT_INIT = 8'(LATENCY - 1);

  typedef enum logic [2:0] {IDLE, ACK, RD_WAIT, RD_BEAT, WR_DATA} state_t;

  state_t                    state;
  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [IDX_W-4:0]          line_idx;
`ifdef SYSBUS_WRAP_BURST_EN
  logic [2:0]                start_off;
`endif
  logic [BUS_TAG_WIDTH-1:0]  tag_q;
  logic [2:0]                beat;
  logic [7:0]                lat_cnt;
  logic                      reqack_q;
  logic                      respcyc_q;
  logic [BUS_DATA_WIDTH-1:0] resp_q;
  logic [BUS_TAG_WIDTH-1:0]  resptag_q;

  function automatic logic [IDX_W-1:0] word_addr(input logic [2:0] b);
`ifdef SYSBUS_WRAP_BURST_EN
    return {line_idx, 3'(start_off + b)};
`else
    return {line_idx, b};
`endif
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      line_idx  <= '0;
`ifdef SYSBUS_WRAP_BURST_EN
      start_off <= '0;
`endif
      tag_q     <= '0;
      beat      <= '0;
      lat_cnt   <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.bus_reqcyc) begin
            line_idx  <= bus.bus_req[IDX_W+2:6];
`ifdef SYSBUS_WRAP_BURST_EN
            start_off <= bus.bus_req[5:3];
`endif
            tag_q     <= bus.bus_reqtag;
            reqack_q  <= 1'b1;
            state     <= ACK;
          end
        end
        ACK: begin
          beat <= '0;
          if (tag_q[BUS_TAG_WIDTH-1]) begin
            reqack_q <= 1'b0;
            lat_cnt  <= LAT_INIT;
            state    <= RD_WAIT;
          end else begin
            // reqack stays high for the whole write data phase
            state <= WR_DATA;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == 8'd0) begin
            respcyc_q <= 1'b1;
            resp_q    <= mem[word_addr(3'd0)];
            resptag_q <= tag_q;
            beat      <= '0;
            state     <= RD_BEAT;
          end else begin
            lat_cnt <= lat_cnt - 8'd1;
          end
        end
        RD_BEAT: begin
          if (bus.bus_respack) begin
            if (beat == 3'd7) begin
              respcyc_q <= 1'b0;
              state     <= IDLE;
            end else begin
              beat   <= beat + 3'd1;
              resp_q <= mem[word_addr(beat + 3'd1)];
            end
          end
        end
        WR_DATA: begin
          if (bus.bus_reqcyc) begin
            if (beat == 3'd7) begin
              reqack_q <= 1'b0;
              beat     <= '0;
              state    <= IDLE;
            end else begin
              beat <= beat + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset so contents survive a reset; an async reset drops state out of WR_DATA at once.
  always_ff @(posedge clk) begin
    if (state == WR_DATA && bus.bus_reqcyc) begin
      mem[word_addr(beat)] <= bus.bus_req;
    end
  end

  assign bus.bus_reqack  = reqack_q;
  assign bus.bus_respcyc = respcyc_q;
  assign bus.bus_resp    = resp_q;
  assign bus.bus_resptag = resptag_q;
endmodule
